// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned FETCH_XLEN  = 64;
  localparam int unsigned FETCH_ILEN  = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h00000013;

  // One queued fetch: the instruction word and the PC it was fetched from.
  typedef struct packed {
    logic [FETCH_ILEN-1:0] instr;
    logic [FETCH_XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic circular buffer of fetch entries with flush; head entry is
// presented first-word-fall-through straight from storage.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  entry_t                 i_data,
  output entry_t                 o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full
);

  localparam int unsigned AW = $clog2(DEPTH);

  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [AW:0]     r_count;

  // Storage: cleared on reset, written at the tail on an unflushed push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_push && !i_flush) begin
      r_mem[r_tail] <= i_data;
    end
  end

  // Pointers and occupancy; flush overrides any push or pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + AW'(1);
      if (i_pop)  r_head <= r_head + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_head];
  assign o_count = r_count;
  assign o_full  = (r_count == (AW+1)'(DEPTH));

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues addresses to
// instruction memory and queues fetched words for decode, with branch flush.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     ILEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [XLEN-1:0]        imem_addr,
  input  logic [ILEN-1:0]        imem_data,
  input  logic                   imem_valid,
  input  logic                   redirect,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   deq_valid,
  input  logic                   deq_ready,
  output logic [ILEN-1:0]        deq_instr,
  output logic [XLEN-1:0]        deq_pc,
  output logic [$clog2(DEPTH):0] count
);

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } entry_t;

  logic [XLEN-1:0]        r_fetch_pc;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic [$clog2(DEPTH):0] w_count;
  logic [XLEN-1:0]        w_target;
  entry_t                 w_wr_entry;
  entry_t                 w_head;
  logic                   w_unused_lsbs;

  assign w_target      = {redirect_pc[XLEN-1:2], 2'b00};
  assign w_unused_lsbs = ^redirect_pc[1:0];

  // Redirect squashes both sides of the queue; a pop frees room for a push
  // into a full queue in the same cycle.
  assign w_pop  = deq_valid && deq_ready && !redirect;
  assign w_push = imem_valid && (!w_full || w_pop) && !redirect;

  assign w_wr_entry.instr = imem_data;
  assign w_wr_entry.pc    = r_fetch_pc;

  // Fetch PC: reload on redirect, advance one instruction per accepted fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc <= RESET_PC;
    end else if (redirect) begin
      r_fetch_pc <= w_target;
    end else if (w_push) begin
      r_fetch_pc <= r_fetch_pc + XLEN'(INSTR_BYTES);
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .i_data  (w_wr_entry),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full)
  );

  assign imem_addr = r_fetch_pc;
  assign count     = w_count;
  assign deq_valid = (w_count != '0);
  assign deq_instr = w_head.instr;
  assign deq_pc    = w_head.pc;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int unsigned     XLEN     = 64;
  localparam int unsigned     ILEN     = 32;
  localparam int unsigned     DEPTH    = 4;
  localparam logic [XLEN-1:0] RESET_PC = 64'h0;

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] imem_addr;
  logic [ILEN-1:0] imem_data;
  logic            imem_valid;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            deq_valid;
  logic            deq_ready;
  logic [ILEN-1:0] deq_instr;
  logic [XLEN-1:0] deq_pc;
  logic [2:0]      count;
  logic [31:0]     mem_key;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  typedef struct {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } ref_ent_t;

  ref_ent_t        mq[$];
  logic [XLEN-1:0] m_pc;

  always #5 clk = ~clk;

  // Memory model: the word at an address is its low 32 bits XOR a key.
  assign imem_data = imem_addr[31:0] ^ mem_key;

  fetch_queue #(
    .XLEN     (XLEN),
    .ILEN     (ILEN),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .imem_valid  (imem_valid),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .deq_valid   (deq_valid),
    .deq_ready   (deq_ready),
    .deq_instr   (deq_instr),
    .deq_pc      (deq_pc),
    .count       (count)
  );

  // Advance one clock; the reference queue applies the same cycle's inputs.
  task automatic tick();
    bit       pop;
    bit       push;
    ref_ent_t e;
    pop  = (mq.size() != 0) && deq_ready;
    push = imem_valid && ((mq.size() < DEPTH) || pop);
    if (redirect) begin
      mq.delete();
      m_pc = {redirect_pc[XLEN-1:2], 2'b00};
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        e.instr = m_pc[31:0] ^ mem_key;
        e.pc    = m_pc;
        mq.push_back(e);
        m_pc = m_pc + 64'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    imem_valid  = 1'b0;
    deq_ready   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    mem_key     = '0;
    rst         = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    mq.delete();
    m_pc = RESET_PC;
  endtask

  task automatic test_reset();
    imem_valid = 1'b0; deq_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    mem_key = '0;
    rst = 1'b0;
    #3;
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count got %0d exp 0", count); end
    vectors++; if (deq_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %0b exp 0", deq_valid); end
    vectors++; if (imem_addr !== RESET_PC) begin miscompares++; $display("FAIL reset_addr got %0h exp %0h", imem_addr, RESET_PC); end
    vectors++; if (deq_pc !== 64'd0) begin miscompares++; $display("FAIL reset_deq_pc got %0h exp 0", deq_pc); end
    vectors++; if (deq_instr !== 32'd0) begin miscompares++; $display("FAIL reset_deq_instr got %0h exp 0", deq_instr); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    mq.delete();
    m_pc = RESET_PC;
  endtask

  task automatic test_stream();
    do_reset();
    imem_valid = 1'b1; deq_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      vectors++; if (imem_addr !== 64'(4*k)) begin miscompares++; $display("FAIL stream_addr got %0h exp %0h", imem_addr, 4*k); end
      tick();
      vectors++; if (deq_pc !== 64'(4*k)) begin miscompares++; $display("FAIL stream_deq_pc got %0h exp %0h", deq_pc, 4*k); end
      vectors++; if (deq_instr !== 32'(4*k)) begin miscompares++; $display("FAIL stream_deq_instr got %0h exp %0h", deq_instr, 4*k); end
      vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL stream_count got %0d exp 1", count); end
    end
  endtask

  task automatic test_backpressure();
    int exp_n;
    do_reset();
    imem_valid = 1'b1; deq_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp_n = (k < 4) ? k : 4;
      vectors++; if (count !== 3'(exp_n)) begin miscompares++; $display("FAIL bp_count got %0d exp %0d", count, exp_n); end
      vectors++; if (imem_addr !== 64'(4*exp_n)) begin miscompares++; $display("FAIL bp_addr got %0h exp %0h", imem_addr, 4*exp_n); end
    end
    deq_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      vectors++; if (deq_valid !== 1'b1) begin miscompares++; $display("FAIL drain_valid got %0b exp 1", deq_valid); end
      vectors++; if (deq_pc !== 64'(4*j)) begin miscompares++; $display("FAIL drain_pc got %0h exp %0h", deq_pc, 4*j); end
      vectors++; if (deq_instr !== 32'(4*j)) begin miscompares++; $display("FAIL drain_instr got %0h exp %0h", deq_instr, 4*j); end
      tick();
    end
  endtask

  task automatic test_full_pushpop();
    do_reset();
    imem_valid = 1'b1; deq_ready = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL full_count got %0d exp 4", count); end
    deq_ready = 1'b1;
    tick();
    deq_ready = 1'b0;
    vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL pushpop_count got %0d exp 4", count); end
    vectors++; if (imem_addr !== 64'd20) begin miscompares++; $display("FAIL pushpop_addr got %0h exp 14", imem_addr); end
    imem_valid = 1'b0; deq_ready = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      vectors++; if (deq_pc !== 64'(4*j)) begin miscompares++; $display("FAIL pushpop_drain_pc got %0h exp %0h", deq_pc, 4*j); end
      tick();
    end
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL pushpop_empty got %0d exp 0", count); end
  endtask

  task automatic test_redirect();
    do_reset();
    imem_valid = 1'b1; deq_ready = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    vectors++; if (count !== 3'd3) begin miscompares++; $display("FAIL redir_pre_count got %0d exp 3", count); end
    redirect = 1'b1; redirect_pc = 64'h103; deq_ready = 1'b1;
    tick();
    redirect = 1'b0; deq_ready = 1'b0;
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL redir_count got %0d exp 0", count); end
    vectors++; if (deq_valid !== 1'b0) begin miscompares++; $display("FAIL redir_valid got %0b exp 0", deq_valid); end
    vectors++; if (imem_addr !== 64'h100) begin miscompares++; $display("FAIL redir_addr got %0h exp 100", imem_addr); end
    tick();
    vectors++; if (deq_pc !== 64'h100) begin miscompares++; $display("FAIL redir_deq_pc got %0h exp 100", deq_pc); end
    vectors++; if (deq_instr !== 32'h100) begin miscompares++; $display("FAIL redir_deq_instr got %0h exp 100", deq_instr); end
    vectors++; if (imem_addr !== 64'h104) begin miscompares++; $display("FAIL redir_next_addr got %0h exp 104", imem_addr); end
  endtask

  task automatic test_wait_states();
    logic [3:0] vseq;
    logic [3:0] exp_v;
    logic [XLEN-1:0] exp_pc [4];
    vseq  = 4'b1001;
    exp_v = 4'b1001;
    exp_pc[0] = 64'd0; exp_pc[1] = 64'd0; exp_pc[2] = 64'd0; exp_pc[3] = 64'd4;
    do_reset();
    deq_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      imem_valid = vseq[3-k];
      tick();
      vectors++; if (deq_valid !== exp_v[3-k]) begin miscompares++; $display("FAIL wait_valid step %0d got %0b exp %0b", k, deq_valid, exp_v[3-k]); end
      if (exp_v[3-k]) begin
        vectors++; if (deq_pc !== exp_pc[k]) begin miscompares++; $display("FAIL wait_pc step %0d got %0h exp %0h", k, deq_pc, exp_pc[k]); end
      end
    end
    vectors++; if (imem_addr !== 64'd8) begin miscompares++; $display("FAIL wait_addr got %0h exp 8", imem_addr); end
  endtask

  task automatic test_async_reset();
    do_reset();
    imem_valid = 1'b1; deq_ready = 1'b0;
    tick(); tick();
    vectors++; if (count !== 3'd2) begin miscompares++; $display("FAIL areset_pre_count got %0d exp 2", count); end
    #2;
    rst = 1'b0;
    #1;
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL areset_count got %0d exp 0", count); end
    vectors++; if (deq_valid !== 1'b0) begin miscompares++; $display("FAIL areset_valid got %0b exp 0", deq_valid); end
    vectors++; if (imem_addr !== RESET_PC) begin miscompares++; $display("FAIL areset_addr got %0h exp %0h", imem_addr, RESET_PC); end
    vectors++; if (deq_pc !== 64'd0) begin miscompares++; $display("FAIL areset_deq_pc got %0h exp 0", deq_pc); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    mq.delete();
    m_pc = RESET_PC;
  endtask

  task automatic test_random();
    do_reset();
    mem_key = $urandom;
    for (int n = 0; n < 600; n++) begin
      imem_valid = ($urandom_range(0, 3) != 0);
      deq_ready  = ($urandom_range(0, 2) != 0);
      redirect   = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 1) == 1) redirect_pc = {$urandom, $urandom};
      else redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) imem_data_note();
      tick();
      vectors++; if (count !== 3'(mq.size())) begin miscompares++; $display("FAIL rand_count cyc %0d got %0d exp %0d", n, count, mq.size()); end
      vectors++; if (count > 3'(DEPTH)) begin miscompares++; $display("FAIL rand_count_bound cyc %0d got %0d exp <=%0d", n, count, DEPTH); end
      vectors++; if (deq_valid !== (mq.size() != 0)) begin miscompares++; $display("FAIL rand_valid cyc %0d got %0b exp %0b", n, deq_valid, mq.size() != 0); end
      vectors++; if (imem_addr !== m_pc) begin miscompares++; $display("FAIL rand_addr cyc %0d got %0h exp %0h", n, imem_addr, m_pc); end
      if (mq.size() != 0) begin
        vectors++; if (deq_pc !== mq[0].pc) begin miscompares++; $display("FAIL rand_deq_pc cyc %0d got %0h exp %0h", n, deq_pc, mq[0].pc); end
        vectors++; if (deq_instr !== mq[0].instr) begin miscompares++; $display("FAIL rand_deq_instr cyc %0d got %0h exp %0h", n, deq_instr, mq[0].instr); end
      end
    end
    redirect = 1'b0;
  endtask

  // Occasionally switch the memory image to a NOP-salted key between cycles;
  // the model picks the key up on its next push just like the DUT.
  task automatic imem_data_note();
    mem_key = NOP_INSTR ^ $urandom_range(0, 255);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_full_pushpop();
    test_redirect();
    test_wait_states();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end for the pipelined RISC-V core. It owns the fetch PC, issues byte addresses to instruction memory, and buffers up to DEPTH fetched instructions with their PCs in a first-in-first-out queue. It sits between InstructionMemory and the IF/ID register. Unlike the single-entry fetch path, it has:

- memory wait states;
- decode back-pressure through a valid/ready handshake;
- a one-cycle branch redirect that flushes the queue.

## Interface
Parameters:
- XLEN, 64, PC and address width in bits.
- ILEN, 32, instruction width in bits.
- DEPTH, 4, queue entries; a power of two, at least 2.
- RESET_PC, 0, fetch PC after reset; must be 4-byte aligned.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_addr  out  XLEN  byte address of the current fetch; equals fetch_pc, driven from a register.
- imem_data  in  ILEN  instruction at imem_addr, read combinationally in the same cycle.
- imem_valid  in  1  imem_data is valid this cycle; low means a memory wait state.
- redirect  in  1  taken branch resolved in ID; flush the queue and restart fetch.
- redirect_pc  in  XLEN  branch target; bits [1:0] are ignored and treated as 0.
- deq_valid  out  1  the head entry is present.
- deq_ready  in  1  ID accepts the head entry (not stalled).
- deq_instr  out  ILEN  instruction of the head entry.
- deq_pc  out  XLEN  PC of the head entry.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation
- Pop: occurs when deq_valid && deq_ready. The head pointer advances by 1, modulo DEPTH.
- Push: occurs when imem_valid && (count<DEPTH || pop). The entry {imem_data, fetch_pc} is written at the tail; the tail advances modulo DEPTH; fetch_pc increases by 4.
- Stall on full: when the queue is full and there is no pop, there is no push. fetch_pc holds, so the same address is re-presented next cycle.
- Wait state: when imem_valid is low there is no push and fetch_pc holds.
- Push and pop in the same cycle: both happen and count is unchanged. This includes the full and empty cases.
- Redirect has the highest priority:
  - head, tail and count are cleared to 0;
  - fetch_pc is loaded with {redirect_pc[XLEN-1:2], 2'b00};
  - any push or pop in that cycle is suppressed. A popped wrong-path entry is discarded; ID must treat it as flushed.
- deq_valid equals (count != 0). deq_instr and deq_pc come straight from the head storage slot (first-word-fall-through).
- fetch_pc wraps modulo 2^XLEN. No alignment fault is raised.

## Timing
- Reset (rst low, asynchronous):
  - fetch_pc and imem_addr become RESET_PC;
  - head, tail and count become 0;
  - every storage entry becomes zero, so deq_valid, deq_instr and deq_pc are 0.
- Release of rst is synchronised by the caller. The first fetch of RESET_PC can push on the first rising edge after release.
- Fetch-to-dequeue latency is 1 cycle: data pushed at edge N is visible on deq_* after edge N, even from empty. There is no bypass from imem_data to deq_*.
- Throughput is 1 instruction per cycle when imem_valid and deq_ready are held high.
- Redirect latency:
  - redirect is sampled at edge N;
  - imem_addr equals the target after edge N;
  - the first target instruction appears on deq_* after edge N+1;
  - this costs 1 bubble cycle after the branch.
- An asserted redirect while the queue is full, empty or in a wait state behaves identically.
- Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.
- count must never exceed DEPTH. Verification asserts count ≤ DEPTH and deq_valid == (count != 0).

## Structure
- Shared package fetch_pkg contains:
  - fetch_entry_t, a struct {logic [ILEN-1:0] instr; logic [XLEN-1:0] pc};
  - INSTR_BYTES = 4;
  - NOP_INSTR = 32'h00000013.
- The natural sub-module is fetch_fifo: a generic circular buffer of fetch_entry_t parametrised by DEPTH, with push, pop and flush inputs and head-entry, count and full outputs.
- fetch_queue keeps the fetch_pc register, the push/pop/redirect decision logic, and the alignment of redirect_pc.

## Test plan
- Reset release, imem_valid=1, deq_ready=1, memory holding instr=PC:
  - imem_addr steps 0, 4, 8;
  - deq_* shows (0,0), (4,4), (8,8) one cycle later;
  - count stays at 1.
- deq_ready=0 for 6 cycles with imem_valid=1:
  - count reaches 4 after 4 edges;
  - imem_addr holds at 16 once full;
  - re-asserting deq_ready drains PCs 0, 4, 8, 12, 16 in order, with no loss or duplication.
- Full queue, then deq_ready=1 for one cycle: push and pop occur together, count stays at 4, and the new tail holds PC 16.
- Redirect with redirect_pc=0x103 while count=3:
  - next cycle count=0, deq_valid=0, imem_addr=0x100;
  - one cycle later deq_pc=0x100.
- imem_valid toggling 1,0,0,1: pushes occur only on the valid cycles, and deq_pc goes 0 then 4 with a 2-cycle gap.
- rst asserted mid-stream with count=2, asynchronous to the clock: count=0, deq_valid=0 and imem_addr=RESET_PC immediately, before the next edge.
